if_id_decode_buffer: RTL and testbench

- Pipeline stage between instruction memory and the sign extender / register-file read stage.
- Accepts fetched {PC, instruction} pairs over a valid/ready handshake and buffers them in a 2-entry skid buffer, so a downstream stall never drops an instruction.
- Pre-decodes each instruction into the sign-extender controls (Inst26, SignOp) plus register indices and an immediate-use flag.
- The downstream stage therefore receives registered, decoded fields with no combinational path from instruction memory.

---
 rtl/if_id_decode_buffer.sv | 244 ++++++++++++++++++++++++
 tb/tb_if_id_decode_buffer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_id_decode_buffer
// Purpose  : IF/ID pipeline stage. Captures fetched {PC, instruction} pairs
//            over a valid/ready handshake into a 2-entry skid buffer and
//            pre-decodes each instruction for the sign extender and the
//            register-file read stage. Every output comes from registers, so
//            there is no combinational path from instruction memory.
// Ports    : CLK, Reset_L (async, active low)
//            InValid/InReady/PCIn/InstIn     - upstream handshake and payload
//            Flush                           - drop every held entry
//            OutValid/OutReady               - downstream handshake
//            PCOut, Inst26, SignOp, UseImm,
//            Rd, Rn, Rm, Illegal             - decoded head entry (0 when idle)
//            StallCycles, FlushDrops         - present only with IFID_PERF_EN
// Options  : `define IFID_PERF_EN adds saturating stall and flush-drop counters
// Revision : 1.0 - initial release
// ============================================================================
module if_id_decode_buffer #(
    parameter int PC_WIDTH = 64
) (
    input  logic                CLK,
    input  logic                Reset_L,
    input  logic                InValid,
    output logic                InReady,
    input  logic [PC_WIDTH-1:0] PCIn,
    input  logic [31:0]         InstIn,
    input  logic                Flush,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [PC_WIDTH-1:0] PCOut,
    output logic [25:0]         Inst26,
    output logic [1:0]          SignOp,
    output logic                UseImm,
    output logic [4:0]          Rd,
    output logic [4:0]          Rn,
    output logic [4:0]          Rm,
    output logic                Illegal
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]         StallCycles,
    output logic [31:0]         FlushDrops
`endif
);

    // Occupancy states
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    // Sign-extender selects
    localparam logic [1:0] c_SOP_I   = 2'b00;
    localparam logic [1:0] c_SOP_D   = 2'b01;
    localparam logic [1:0] c_SOP_B   = 2'b10;
    localparam logic [1:0] c_SOP_CBZ = 2'b11;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_head;
    logic                w_head_nxt;
    logic                r_in_en;      // holds InReady low until the first edge after reset

    // Two storage slots; only the bits the outputs need are kept.
    logic [PC_WIDTH-1:0] r_slot_pc      [2];
    logic [25:0]         r_slot_inst    [2];
    logic [1:0]          r_slot_signop  [2];
    logic                r_slot_useimm  [2];
    logic                r_slot_illegal [2];

    logic [1:0]          w_dec_signop;
    logic                w_dec_useimm;
    logic                w_dec_illegal;
    logic                w_accept;
    logic                w_pop;
    logic                w_wr_idx;

    // ------------------------------------------------------------------
    // Pre-decode of the incoming word; earlier rows take priority.
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_signop  = c_SOP_I;
        w_dec_useimm  = 1'b0;
        w_dec_illegal = 1'b0;
        if (InstIn[31:26] == 6'b000101) begin
            w_dec_signop = c_SOP_B;
            w_dec_useimm = 1'b1;
        end else if (InstIn[31:24] == 8'b10110100) begin
            w_dec_signop = c_SOP_CBZ;
            w_dec_useimm = 1'b1;
        end else if ((InstIn[31:21] == 11'b11111000010) ||
                     (InstIn[31:21] == 11'b11111000000)) begin
            w_dec_signop = c_SOP_D;
            w_dec_useimm = 1'b1;
        end else if ((InstIn[31:22] == 10'b1001000100) ||
                     (InstIn[31:22] == 10'b1101000100)) begin
            w_dec_signop = c_SOP_I;
            w_dec_useimm = 1'b1;
        end else if ((InstIn[31:21] == 11'b10001011000) ||
                     (InstIn[31:21] == 11'b11001011000) ||
                     (InstIn[31:21] == 11'b10001010000) ||
                     (InstIn[31:21] == 11'b10101010000)) begin
            w_dec_signop = c_SOP_I;
            w_dec_useimm = 1'b0;
        end else begin
            w_dec_illegal = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake and occupancy
    // ------------------------------------------------------------------
    assign OutValid = (r_state == c_ST_ONE) || (r_state == c_ST_TWO);
    assign InReady  = r_in_en && (r_state != c_ST_TWO);
    assign w_accept = InValid && InReady;
    assign w_pop    = OutValid && OutReady;

    // With one entry held, the new word goes in the slot behind the head;
    // otherwise the buffer is empty and the head slot itself is free.
    assign w_wr_idx = r_head ^ (r_state == c_ST_ONE);

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        if (Flush) begin
            w_state_nxt = c_ST_EMPTY;
            w_head_nxt  = 1'b0;
        end else begin
            case (r_state)
                c_ST_EMPTY: begin
                    if (w_accept) w_state_nxt = c_ST_ONE;
                end
                c_ST_ONE: begin
                    // A pop always advances the head; with a simultaneous
                    // accept the new word (written behind the head) takes over.
                    w_head_nxt = r_head ^ w_pop;
                    if (w_accept && !w_pop)      w_state_nxt = c_ST_TWO;
                    else if (!w_accept && w_pop) w_state_nxt = c_ST_EMPTY;
                end
                c_ST_TWO: begin
                    w_head_nxt = r_head ^ w_pop;
                    if (w_pop) w_state_nxt = c_ST_ONE;
                end
                default: begin
                    w_state_nxt = c_ST_EMPTY;
                    w_head_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= c_ST_EMPTY;
            r_head  <= 1'b0;
            r_in_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_in_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Slot storage
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_slot_pc[0]      <= '0;
            r_slot_pc[1]      <= '0;
            r_slot_inst[0]    <= '0;
            r_slot_inst[1]    <= '0;
            r_slot_signop[0]  <= '0;
            r_slot_signop[1]  <= '0;
            r_slot_useimm[0]  <= 1'b0;
            r_slot_useimm[1]  <= 1'b0;
            r_slot_illegal[0] <= 1'b0;
            r_slot_illegal[1] <= 1'b0;
        end else if (w_accept && !Flush) begin
            r_slot_pc[w_wr_idx]      <= PCIn;
            r_slot_inst[w_wr_idx]    <= InstIn[25:0];
            r_slot_signop[w_wr_idx]  <= w_dec_signop;
            r_slot_useimm[w_wr_idx]  <= w_dec_useimm;
            r_slot_illegal[w_wr_idx] <= w_dec_illegal;
        end
    end

    // ------------------------------------------------------------------
    // Head presentation; all data forced to 0 while nothing is held
    // ------------------------------------------------------------------
    always_comb begin
        PCOut   = '0;
        Inst26  = '0;
        SignOp  = '0;
        UseImm  = 1'b0;
        Rd      = '0;
        Rn      = '0;
        Rm      = '0;
        Illegal = 1'b0;
        if (OutValid) begin
            PCOut   = r_slot_pc[r_head];
            Inst26  = r_slot_inst[r_head];
            SignOp  = r_slot_signop[r_head];
            UseImm  = r_slot_useimm[r_head];
            Rd      = r_slot_inst[r_head][4:0];
            Rn      = r_slot_inst[r_head][9:5];
            Rm      = r_slot_inst[r_head][20:16];
            Illegal = r_slot_illegal[r_head];
        end
    end

`ifdef IFID_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fdrop_cnt;
    logic [1:0]  w_held_cnt;
    logic [32:0] w_fdrop_sum;

    assign w_held_cnt  = (r_state == c_ST_TWO) ? 2'd2 :
                         (r_state == c_ST_ONE) ? 2'd1 : 2'd0;
    // An offered word is counted as dropped even if it could not be accepted.
    assign w_fdrop_sum = {1'b0, r_fdrop_cnt} + {31'd0, w_held_cnt} + {32'd0, InValid};

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_stall_cnt <= '0;
            r_fdrop_cnt <= '0;
        end else begin
            if (OutValid && !OutReady && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (Flush) begin
                r_fdrop_cnt <= w_fdrop_sum[32] ? 32'hFFFF_FFFF : w_fdrop_sum[31:0];
            end
        end
    end

    assign StallCycles = r_stall_cnt;
    assign FlushDrops  = r_fdrop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_decode_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_decode_buffer
// Purpose  : Self-checking bench for if_id_decode_buffer. A queue-based
//            model of the buffer plus a table-driven decoder predicts every
//            output each cycle; directed steps cover the named instruction
//            cases, backpressure, flush and async reset, followed by a
//            randomized run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_decode_buffer;

    localparam int PC_WIDTH = 64;

    logic                CLK = 1'b0;
    logic                Reset_L;
    logic                InValid;
    logic                InReady;
    logic [PC_WIDTH-1:0] PCIn;
    logic [31:0]         InstIn;
    logic                Flush;
    logic                OutValid;
    logic                OutReady;
    logic [PC_WIDTH-1:0] PCOut;
    logic [25:0]         Inst26;
    logic [1:0]          SignOp;
    logic                UseImm;
    logic [4:0]          Rd;
    logic [4:0]          Rn;
    logic [4:0]          Rm;
    logic                Illegal;
`ifdef IFID_PERF_EN
    logic [31:0]         StallCycles;
    logic [31:0]         FlushDrops;
`endif

    if_id_decode_buffer #(.PC_WIDTH(PC_WIDTH)) dut (
        .CLK      (CLK),
        .Reset_L  (Reset_L),
        .InValid  (InValid),
        .InReady  (InReady),
        .PCIn     (PCIn),
        .InstIn   (InstIn),
        .Flush    (Flush),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .PCOut    (PCOut),
        .Inst26   (Inst26),
        .SignOp   (SignOp),
        .UseImm   (UseImm),
        .Rd       (Rd),
        .Rn       (Rn),
        .Rm       (Rm),
        .Illegal  (Illegal)
`ifdef IFID_PERF_EN
        ,
        .StallCycles (StallCycles),
        .FlushDrops  (FlushDrops)
`endif
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         inst;
    } ent_t;

    ent_t        q[$];
    logic        m_rdy_en;
    logic [31:0] m_stall;
    logic [31:0] m_drops;

    int total = 0;
    int bad   = 0;

    // Returns {SignOp, UseImm, Illegal} from the decode table.
    function automatic logic [3:0] ref_dec(input logic [31:0] i);
        logic [10:0] op11;
        op11 = i[31:21];
        if (i[31:26] == 6'b000101)                         return 4'b10_1_0;
        if (i[31:24] == 8'hB4)                             return 4'b11_1_0;
        if (op11 == 11'h7C2 || op11 == 11'h7C0)            return 4'b01_1_0;
        if (i[31:22] == 10'h244 || i[31:22] == 10'h344)    return 4'b00_1_0;
        if (op11 == 11'h458 || op11 == 11'h658 ||
            op11 == 11'h450 || op11 == 11'h550)            return 4'b00_0_0;
        return 4'b00_0_1;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic acc;
        logic pop;
        ent_t e;
        acc = InValid && m_rdy_en && (q.size() < 2);
        pop = (q.size() > 0) && OutReady;
        if ((q.size() > 0) && !OutReady && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (Flush) begin
            m_drops = m_drops + 32'(q.size()) + 32'(InValid);
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.pc   = PCIn;
                e.inst = InstIn;
                q.push_back(e);
            end
        end
        m_rdy_en = 1'b1;
    endtask

    task automatic check_all(input string tag);
        logic [110:0] exp_v;
        logic [3:0]   d;
        logic         ir;
        ent_t         h;
        ir = m_rdy_en && (q.size() < 2);
        if (q.size() > 0) begin
            h = q[0];
            d = ref_dec(h.inst);
            exp_v = {1'b1, ir, h.pc, h.inst[25:0], d[3:2], d[1],
                     h.inst[4:0], h.inst[9:5], h.inst[20:16], d[0]};
        end else begin
            exp_v = {1'b0, ir, 109'd0};
        end
        chk(tag, 128'({OutValid, InReady, PCOut, Inst26, SignOp, UseImm, Rd, Rn, Rm, Illegal}),
            128'(exp_v));
`ifdef IFID_PERF_EN
        chk({tag, "_stall"}, 128'(StallCycles), 128'(m_stall));
        chk({tag, "_fdrop"}, 128'(FlushDrops), 128'(m_drops));
`endif
    endtask

    task automatic step(input logic iv, input logic [PC_WIDTH-1:0] pc, input logic [31:0] inst,
                        input logic fl, input logic ordy, input string tag);
        InValid  = iv;
        PCIn     = pc;
        InstIn   = inst;
        Flush    = fl;
        OutReady = ordy;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 10))
            0:       return {6'b000101, r[25:0]};
            1:       return {8'hB4, r[23:0]};
            2:       return {11'h7C2, r[20:0]};
            3:       return {11'h7C0, r[20:0]};
            4:       return {10'h244, r[21:0]};
            5:       return {10'h344, r[21:0]};
            6:       return {11'h458, r[20:0]};
            7:       return {11'h658, r[20:0]};
            8:       return {11'h450, r[20:0]};
            9:       return {11'h550, r[20:0]};
            default: return r;
        endcase
    endfunction

    initial begin
        q.delete();
        m_rdy_en = 1'b0;
        m_stall  = '0;
        m_drops  = '0;
        Reset_L  = 1'b0;
        InValid  = 1'b0;
        PCIn     = '0;
        InstIn   = '0;
        Flush    = 1'b0;
        OutReady = 1'b0;

        // Reset state
        #1;
        check_all("reset");
        repeat (2) @(posedge CLK);
        #3 Reset_L = 1'b1;
        #1 chk("inready_before_first_edge", 128'(InReady), 128'(0));
        step(1'b0, '0, '0, 1'b0, 1'b1, "post_reset");
        chk("inready_after_release", 128'(InReady), 128'(1));

        // Directed decode cases, streaming at full throughput
        step(1'b1, 64'h1000, 32'h9100_1441, 1'b0, 1'b1, "addi");
        chk("addi_fields", 128'({OutValid, SignOp, UseImm, Inst26, Rd, Rn, Illegal}),
            128'({1'b1, 2'b00, 1'b1, 26'h100_1441, 5'd1, 5'd2, 1'b0}));
        step(1'b1, 64'h1004, 32'h17FF_FFFF, 1'b0, 1'b1, "b");
        chk("b_fields", 128'({SignOp, Inst26, UseImm}), 128'({2'b10, 26'h3FF_FFFF, 1'b1}));
        step(1'b1, 64'h1008, 32'hB400_0083, 1'b0, 1'b1, "cbz");
        chk("cbz_fields", 128'({SignOp, Rd}), 128'({2'b11, 5'd3}));
        step(1'b1, 64'h100C, 32'hF840_8020, 1'b0, 1'b1, "ldur");
        chk("ldur_fields", 128'({SignOp, Rn, Rd}), 128'({2'b01, 5'd1, 5'd0}));
        step(1'b1, 64'h1010, 32'h0000_0000, 1'b0, 1'b1, "zero");
        chk("zero_illegal", 128'({Illegal, UseImm}), 128'({1'b1, 1'b0}));
        step(1'b0, '0, '0, 1'b0, 1'b1, "drain0");

        // Backpressure: two accepts fill the buffer, the third word waits
        step(1'b1, 64'h100, 32'h8B02_0020, 1'b0, 1'b0, "bp_push0");
        step(1'b1, 64'h104, 32'hCB02_0020, 1'b0, 1'b0, "bp_push1");
        chk("bp_full", 128'(InReady), 128'(0));
        step(1'b1, 64'h108, 32'h8A02_0020, 1'b0, 1'b0, "bp_push2");
        chk("bp_head_held", 128'(PCOut), 128'(64'h100));
        step(1'b0, '0, '0, 1'b0, 1'b1, "bp_pop0");
        chk("bp_second", 128'(PCOut), 128'(64'h104));
        step(1'b0, '0, '0, 1'b0, 1'b1, "bp_pop1");
        chk("bp_empty", 128'(OutValid), 128'(0));

        // Flush while two entries are held and a new word is offered
        step(1'b1, 64'h200, 32'h9100_0000, 1'b0, 1'b0, "fl_fill0");
        step(1'b1, 64'h204, 32'h9100_0001, 1'b0, 1'b0, "fl_fill1");
        step(1'b1, 64'h208, 32'h9100_0002, 1'b1, 1'b0, "flush");
        chk("flush_state", 128'({OutValid, InReady}), 128'({1'b0, 1'b1}));
`ifdef IFID_PERF_EN
        chk("flush_drops", 128'(FlushDrops), 128'(32'd3));
`endif

        // Asynchronous reset between edges while one entry is held
        step(1'b1, 64'h300, 32'hB400_0001, 1'b0, 1'b0, "ar_one");
        #2 Reset_L = 1'b0;
        #1;
        q.delete();
        m_rdy_en = 1'b0;
        m_stall  = '0;
        m_drops  = '0;
        chk("async_reset_outvalid", 128'({OutValid, InReady, PCOut}), 128'(0));
        #2 Reset_L = 1'b1;
        step(1'b1, 64'h1FFC, 32'h9100_1441, 1'b0, 1'b1, "ar_first_edge");
        step(1'b1, 64'h2000, 32'h9100_1441, 1'b0, 1'b1, "ar_accept");
        chk("ar_latency", 128'({OutValid, PCOut}), 128'({1'b1, 64'h2000}));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 {$urandom, $urandom},
                 gen_inst(),
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
